// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_types (package)
//  Purpose  : Shared types for the CPU memory interface: the RAM status
//             encoding, the memory arbiter state encoding and the word type.
//  Ports    : n/a (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_types;

   localparam int CPU_WORD_W = 32;

   typedef logic [CPU_WORD_W-1:0] word_t;

   // Status reported by the RAM model on its ramstate port.
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   // Memory arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2,
      DONE   = 2'd3
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module   : arb_timeout_counter
//  Purpose  : Counts stalled grant cycles and flags the cycle whose increment
//             would reach TIMEOUT, so the arbiter can abort on that same edge.
//  Ports    : clk_i  - clock
//             rst_i  - synchronous active-high reset
//             clr_i  - synchronous clear (dominates en_i)
//             en_i   - count this cycle
//             tc_o   - terminal count: en_i is high and this increment is the
//                      TIMEOUT-th one
//  Revision : 1.0 - initial release
// ============================================================================
module arb_timeout_counter #(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flag on the increment that takes the count to TIMEOUT; the arbiter
   // leaves the grant state on that edge, which also clears the count.
   assign tc_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Responder end of the CPU memory request interface. Arbitrates
//             instruction reads and data reads/writes onto a single-ported
//             RAM and returns one-cycle ihit/dhit pulses with load data.
//  Ports    : CLK, RST           - clock, synchronous active-high reset
//             iREN, iaddr        - instruction read request / address
//             dREN, dWEN         - data read / write request
//             daddr, dstore      - data address / write value
//             ihit, iload        - instruction hit pulse / fetched word
//             dhit, dload        - data hit pulse / read word (0 on write)
//             ramREN, ramWEN     - RAM read / write enables
//             ramaddr, ramstore  - RAM address / write data
//             ramload, ramstate  - RAM read data / status
//             mem_err            - sticky error (RAM ERROR or timeout)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import cpu_types::*;
#(
   parameter int WORD_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              ihit,
   output logic [WORD_W-1:0] iload,
   output logic              dhit,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              mem_err
);

   arb_state_t        state_q, state_d;
   logic              prio_q, prio_d;     // 1: instruction wins next tie
   logic              wen_q, wen_d;       // latched type of data grant
   logic              ihit_q, ihit_d;
   logic              dhit_q, dhit_d;
   logic [WORD_W-1:0] iload_q, iload_d;
   logic [WORD_W-1:0] dload_q, dload_d;
   logic              ramren_q, ramren_d;
   logic              ramwen_q, ramwen_d;
   logic [WORD_W-1:0] ramaddr_q, ramaddr_d;
   logic [WORD_W-1:0] ramstore_q, ramstore_d;
   logic              err_q, err_d;

   ramstate_t w_rs;
   logic      w_in_grant;
   logic      w_req_held;
   logic      w_tc;
   logic      w_cnt_clr;
   logic      w_cnt_en;
   logic      w_grant_i, w_grant_d, w_complete, w_abort, w_fail;

   assign w_rs       = ramstate_t'(ramstate);
   assign w_in_grant = (state_q == IGRANT) || (state_q == DGRANT);

   // The enable that started the current grant must still be asserted;
   // otherwise the requester has withdrawn.
   assign w_req_held = (state_q == IGRANT) ? iREN : (wen_q ? dWEN : dREN);

   // Count stalled grant cycles; clear whenever the next state is not a grant
   // so every grant starts from zero.
   assign w_cnt_en  = w_in_grant && (w_rs != ACCESS);
   assign w_cnt_clr = (state_d != IGRANT) && (state_d != DGRANT);

   arb_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i (CLK),
      .rst_i (RST),
      .clr_i (w_cnt_clr),
      .en_i  (w_cnt_en),
      .tc_o  (w_tc)
   );

   // ------------------------------------------------------------------
   // State register (together with the registered outputs)
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         prio_q     <= 1'b0;
         wen_q      <= 1'b0;
         ihit_q     <= 1'b0;
         dhit_q     <= 1'b0;
         iload_q    <= '0;
         dload_q    <= '0;
         ramren_q   <= 1'b0;
         ramwen_q   <= 1'b0;
         ramaddr_q  <= '0;
         ramstore_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         wen_q      <= wen_d;
         ihit_q     <= ihit_d;
         dhit_q     <= dhit_d;
         iload_q    <= iload_d;
         dload_q    <= dload_d;
         ramren_q   <= ramren_d;
         ramwen_q   <= ramwen_d;
         ramaddr_q  <= ramaddr_d;
         ramstore_q <= ramstore_d;
         err_q      <= err_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic; also classifies what happens on this edge.
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      w_grant_i  = 1'b0;
      w_grant_d  = 1'b0;
      w_complete = 1'b0;
      w_abort    = 1'b0;
      w_fail     = 1'b0;
      case (state_q)
         IDLE: begin
            // Data wins unless the instruction side holds priority and is
            // actually requesting.
            if ((dREN || dWEN) && !(prio_q && iREN)) begin
               state_d   = DGRANT;
               w_grant_d = 1'b1;
            end else if (iREN) begin
               state_d   = IGRANT;
               w_grant_i = 1'b1;
            end
         end
         IGRANT, DGRANT: begin
            if (w_rs == ERROR) begin
               state_d = DONE;
               w_fail  = 1'b1;
            end else if (!w_req_held) begin
               state_d = IDLE;
               w_abort = 1'b1;
            end else if (w_rs == ACCESS) begin
               state_d    = DONE;
               w_complete = 1'b1;
            end else if (w_tc) begin
               state_d = DONE;
               w_fail  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic: next values of the registered outputs.
   // ------------------------------------------------------------------
   always_comb begin
      prio_d     = prio_q;
      wen_d      = wen_q;
      ihit_d     = 1'b0;
      dhit_d     = 1'b0;
      iload_d    = iload_q;
      dload_d    = dload_q;
      ramren_d   = ramren_q;
      ramwen_d   = ramwen_q;
      ramaddr_d  = ramaddr_q;
      ramstore_d = ramstore_q;
      err_d      = err_q;

      if (w_grant_d) begin
         wen_d      = dWEN;
         ramren_d   = !dWEN;
         ramwen_d   = dWEN;
         ramaddr_d  = daddr;
         ramstore_d = dstore;
      end else if (w_grant_i) begin
         ramren_d  = 1'b1;
         ramwen_d  = 1'b0;
         ramaddr_d = iaddr;
      end

      if (w_complete || w_abort || w_fail) begin
         ramren_d = 1'b0;
         ramwen_d = 1'b0;
      end

      if (w_complete) begin
         if (state_q == IGRANT) begin
            ihit_d  = 1'b1;
            iload_d = ramload;
            prio_d  = 1'b0;
         end else begin
            dhit_d  = 1'b1;
            dload_d = wen_q ? '0 : ramload;
            prio_d  = 1'b1;
         end
      end

      if (w_fail) begin
         err_d = 1'b1;
      end
   end

   assign ihit     = ihit_q;
   assign iload    = iload_q;
   assign dhit     = dhit_q;
   assign dload    = dload_q;
   assign ramREN   = ramren_q;
   assign ramWEN   = ramwen_q;
   assign ramaddr  = ramaddr_q;
   assign ramstore = ramstore_q;
   assign mem_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. A RAM model answers the
//             arbiter's grants; expected grants and hits are queued when
//             requests are issued and compared by independent processes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
   import cpu_types::*;

   localparam int W  = 32;
   localparam int TO = 16;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         iREN, dREN, dWEN;
   logic [W-1:0] iaddr, daddr, dstore;
   logic         ihit, dhit, ramREN, ramWEN, mem_err;
   logic [W-1:0] iload, dload, ramaddr, ramstore, ramload;
   logic [1:0]   ramstate;

   mem_arbiter #(.WORD_W(W), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      bit    is_i;
      bit    wr;
      word_t addr;
      word_t store;
   } txn_t;

   txn_t grant_q[$];   // expected order of RAM accesses
   txn_t exp_q[$];     // expected order of hits

   int n_chk = 0;
   int n_err = 0;

   int ram_mode  = 0;  // 0 normal, 1 stuck BUSY, 2 ERROR
   int ram_lat   = 0;  // BUSY cycles before ACCESS
   int hit_cyc   = -100;
   int last_acc  = -100;
   int grant_cyc = -100;
   bit prio_m    = 1'b0;  // reference model of the fairness rule

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic word_t ram_data(input word_t a);
      if (a == 32'h40)  return 32'h8C010004;
      if (a == 32'h200) return 32'h12345678;
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // ------------------------------------------------------------------
   // RAM model: answers grants and checks grant order and stability.
   // ------------------------------------------------------------------
   initial begin : ram_model
      bit    act;
      int    left;
      word_t cur_addr;
      bit    cur_wen;
      txn_t  g;
      act = 1'b0;
      left = 0;
      cur_addr = '0;
      cur_wen = 1'b0;
      ramstate = FREE;
      ramload = '0;
      forever begin
         @(posedge CLK); #1;
         if (!RST && (ramREN || ramWEN)) begin
            if (!act) begin
               act       = 1'b1;
               cur_addr  = ramaddr;
               cur_wen   = ramWEN;
               left      = ram_lat;
               grant_cyc = cyc;
               chk("grant_spacing", 32'(cyc >= last_acc + 2), 32'd1);
               if (grant_q.size() == 0) begin
                  chk("unexpected_grant", ramaddr, 32'hFFFF_FFFF);
               end else begin
                  g = grant_q.pop_front();
                  chk("grant_enables", 32'({ramREN, ramWEN}),
                      (g.is_i || !g.wr) ? 32'b10 : 32'b01);
                  chk("grant_addr", ramaddr, g.addr);
                  if (g.wr) chk("grant_store", ramstore, g.store);
               end
            end else begin
               chk("hold_addr", ramaddr, cur_addr);
               chk("hold_enables", 32'({ramREN, ramWEN}), cur_wen ? 32'b01 : 32'b10);
            end
            if (ram_mode == 1) begin
               ramstate = BUSY;
            end else if (ram_mode == 2) begin
               ramstate = ERROR;
            end else if (left > 0) begin
               ramstate = BUSY;
               left--;
            end else begin
               ramstate = ACCESS;
               ramload  = cur_wen ? word_t'($urandom) : ram_data(cur_addr);
               hit_cyc  = cyc + 1;
               last_acc = cyc + 1;
            end
         end else begin
            act      = 1'b0;
            ramstate = FREE;
            ramload  = word_t'($urandom);
         end
      end
   end

   // ------------------------------------------------------------------
   // Hit monitor: pops the scoreboard on every hit.
   // ------------------------------------------------------------------
   initial begin : monitor
      txn_t e;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            if (ihit || dhit) begin
               chk("hit_overlap", 32'(ihit & dhit), 32'd0);
               chk("hit_timing", 32'(cyc), 32'(hit_cyc));
               chk("hit_enables_low", 32'({ramREN, ramWEN}), 32'd0);
               if (exp_q.size() == 0) begin
                  chk("unexpected_hit", 32'({ihit, dhit}), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("hit_kind", 32'(ihit), 32'(e.is_i));
                  if (e.is_i) chk("iload", iload, ram_data(e.addr));
                  else        chk("dload", dload, e.wr ? 32'd0 : ram_data(e.addr));
               end
            end else if (cyc == hit_cyc) begin
               chk("missing_hit", 32'd0, 32'd1);
            end
         end
      end
   end

   // One transaction pair; expected order comes from the arbitration rules:
   // the request seen first wins, ties go to data unless prio_m is set.
   task automatic run_scen(input bit wi, input bit wd, input bit wr,
                           input word_t ia, input word_t da, input word_t ds,
                           input int di, input int dd, input int lat);
      txn_t ti, td;
      bit   d_first;
      int   pend;
      ti = '{1'b1, 1'b0, ia, 32'd0};
      td = '{1'b0, wr, da, ds};
      if (wi && wd) begin
         if (dd < di)      d_first = 1'b1;
         else if (di < dd) d_first = 1'b0;
         else              d_first = !prio_m;
         if (d_first) begin
            grant_q.push_back(td); grant_q.push_back(ti);
            exp_q.push_back(td);   exp_q.push_back(ti);
            prio_m = 1'b0;
         end else begin
            grant_q.push_back(ti); grant_q.push_back(td);
            exp_q.push_back(ti);   exp_q.push_back(td);
            prio_m = 1'b1;
         end
      end else if (wi) begin
         grant_q.push_back(ti); exp_q.push_back(ti); prio_m = 1'b0;
      end else if (wd) begin
         grant_q.push_back(td); exp_q.push_back(td); prio_m = 1'b1;
      end
      pend     = int'(wi) + int'(wd);
      ram_mode = 0;
      ram_lat  = lat;
      for (int t = 0; t < 80 && pend > 0; t++) begin
         if (wi && t == di) begin iREN = 1'b1; iaddr = ia; end
         if (wd && t == dd) begin
            if (wr) dWEN = 1'b1; else dREN = 1'b1;
            daddr = da; dstore = ds;
         end
         @(posedge CLK); #1;
         if (ihit) begin iREN = 1'b0; pend--; end
         if (dhit) begin dREN = 1'b0; dWEN = 1'b0; pend--; end
      end
      chk("scenario_complete", 32'(pend), 32'd0);
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
   endtask

   // Raise a data read against a stuck RAM and wait for its grant.
   task automatic start_stuck_read(input word_t a, input int mode);
      grant_q.push_back('{1'b0, 1'b0, a, 32'd0});
      ram_mode = mode;
      dREN  = 1'b1;
      daddr = a;
      for (int t = 0; t < 10 && !(ramREN === 1'b1); t++) begin
         @(posedge CLK); #1;
      end
      chk("stuck_grant_seen", 32'(ramREN), 32'd1);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_flags", 32'({ihit, dhit, ramREN, ramWEN, mem_err}), 32'd0);
      chk("reset_iload", iload, 32'd0);
      chk("reset_dload", dload, 32'd0);
      chk("reset_ramaddr", ramaddr, 32'd0);
      chk("reset_ramstore", ramstore, 32'd0);
      RST = 1'b0;
      @(posedge CLK); #1;

      // Single fetch, ACCESS right after the grant.
      run_scen(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 0, 0, 0);
      // Simultaneous fetch and write: the write goes first.
      run_scen(1'b1, 1'b1, 1'b1, 32'h80, 32'h100, 32'hDEADBEEF, 0, 0, 0);
      // Tie again: priority is back with data after the fetch completed.
      run_scen(1'b1, 1'b1, 1'b0, 32'h84, 32'h104, 32'h0, 0, 0, 1);
      // Data read through three BUSY cycles.
      run_scen(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 0, 0, 3);

      for (int k = 0; k < 24; k++) begin
         int m;
         m = int'($urandom_range(0, 2));
         run_scen(m != 1, m != 0, $urandom_range(0, 1) == 1,
                  word_t'($urandom_range(0, 1023)) << 2,
                  word_t'($urandom_range(0, 1023)) << 2,
                  word_t'($urandom),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 4)));
      end

      // Stall until the timeout fires.
      start_stuck_read(32'h300, 1);
      for (int t = 0; t < 40 && mem_err !== 1'b1; t++) begin
         @(posedge CLK); #1;
      end
      chk("timeout_cycles", 32'(cyc - grant_cyc), 32'(TO));
      chk("timeout_enables_low", 32'({ramREN, ramWEN}), 32'd0);
      dREN = 1'b0;
      ram_mode = 0;
      repeat (4) @(posedge CLK);
      #1;
      run_scen(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 0, 0, 0);
      chk("err_sticky", 32'(mem_err), 32'd1);

      // Reset in the middle of a data grant.
      start_stuck_read(32'h340, 1);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("rst_mid_flags", 32'({ihit, dhit, ramREN, ramWEN, mem_err}), 32'd0);
      chk("rst_mid_ramaddr", ramaddr, 32'd0);
      chk("rst_mid_loads", iload | dload, 32'd0);
      RST = 1'b0; dREN = 1'b0; ram_mode = 0; prio_m = 1'b0;
      @(posedge CLK); #1;
      run_scen(1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 0, 0, 0);

      // Withdraw a data read after two BUSY cycles.
      start_stuck_read(32'h380, 1);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      dREN = 1'b0;
      @(posedge CLK); #1;
      chk("withdraw_enables_low", 32'({ramREN, ramWEN}), 32'd0);
      ram_mode = 0;
      repeat (3) @(posedge CLK);
      #1;
      chk("withdraw_no_err", 32'(mem_err), 32'd0);
      run_scen(1'b1, 1'b1, 1'b0, 32'h4C, 32'h3C0, 32'h0, 1, 0, 2);

      // RAM reports ERROR on the first grant cycle.
      start_stuck_read(32'h3C4, 2);
      for (int t = 0; t < 10 && mem_err !== 1'b1; t++) begin
         @(posedge CLK); #1;
      end
      chk("ramerr_cycles", 32'(cyc - grant_cyc), 32'd1);
      chk("ramerr_enables_low", 32'({ramREN, ramWEN}), 32'd0);
      dREN = 1'b0;
      ram_mode = 0;
      repeat (4) @(posedge CLK);
      #1;
      chk("scoreboard_empty", 32'(exp_q.size() + grant_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
